// File: rtl/hb_chinfo_parser.sv
// Heartbeat packet parser: extracts the CH limit and CH records
// from a received byte stream for the known-CH selection stage.
module hb_chinfo_parser #(
  parameter logic [7:0] HB_TYPE = 8'h01,
  parameter int         MAX_REC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_sop,
  input  logic        rx_eop,
  output logic        HB_reset,
  output logic [15:0] HB_CHlimit,
  output logic        en_KCH,
  output logic [15:0] fCH_ID,
  output logic [15:0] fCH_Hops,
  output logic [15:0] fCH_QValue,
  output logic        pkt_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_REC  = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [8:0] MAX_W = 9'(MAX_REC);

  logic [1:0]  state;
  logic [1:0]  hdr_idx;
  logic [7:0]  lim_hi;
  logic [7:0]  lim_lo;
  logic [7:0]  n_rec;
  logic [2:0]  byte_idx;
  logic [7:0]  rec_idx;
  logic [39:0] asm_q;

  logic [47:0] rec_w;
  logic [16:0] hops_sum;
  logic [15:0] hops_sat;
  logic        rec_fwd;
  logic        last_rec;

  // Complete record as seen on the cycle its sixth byte arrives.
  assign rec_w    = {asm_q, rx_byte};
  assign hops_sum = {1'b0, rec_w[31:16]} + 17'd1;
  assign hops_sat = hops_sum[16] ? 16'hFFFF
                                 : hops_sum[15:0];
  assign rec_fwd  = ({1'b0, rec_idx} < MAX_W);
  assign last_rec = ((rec_idx + 8'd1) == n_rec);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hdr_idx    <= 2'd0;
      lim_hi     <= 8'd0;
      lim_lo     <= 8'd0;
      n_rec      <= 8'd0;
      byte_idx   <= 3'd0;
      rec_idx    <= 8'd0;
      asm_q      <= 40'd0;
      HB_reset   <= 1'b0;
      HB_CHlimit <= 16'd0;
      en_KCH     <= 1'b0;
      fCH_ID     <= 16'd0;
      fCH_Hops   <= 16'hFFFF;
      fCH_QValue <= 16'd0;
      pkt_err    <= 1'b0;
    end else begin
      HB_reset <= 1'b0;
      en_KCH   <= 1'b0;
      pkt_err  <= 1'b0;
      if (rx_valid) begin
        if (rx_sop) begin
          // A sop restarts parsing from any state.
          hdr_idx  <= 2'd1;
          byte_idx <= 3'd0;
          rec_idx  <= 8'd0;
          if (rx_eop)
            state <= S_IDLE;
          else if (rx_byte == HB_TYPE)
            state <= S_HDR;
          else
            state <= S_DROP;
        end else begin
          case (state)
            S_HDR: begin
              hdr_idx <= hdr_idx + 2'd1;
              case (hdr_idx)
                2'd1:    lim_hi <= rx_byte;
                2'd2:    lim_lo <= rx_byte;
                default: n_rec  <= rx_byte;
              endcase
              if (hdr_idx == 2'd3) begin
                HB_reset   <= 1'b1;
                HB_CHlimit <= {lim_hi, lim_lo};
                if (rx_eop || rx_byte == 8'd0)
                  state <= S_IDLE;
                else
                  state <= S_REC;
              end else if (rx_eop) begin
                pkt_err <= 1'b1;
                state   <= S_IDLE;
              end
            end
            S_REC: begin
              asm_q <= {asm_q[31:0], rx_byte};
              if (byte_idx == 3'd5) begin
                byte_idx <= 3'd0;
                rec_idx  <= rec_idx + 8'd1;
                if (rec_fwd) begin
                  en_KCH     <= 1'b1;
                  fCH_ID     <= rec_w[47:32];
                  fCH_Hops   <= hops_sat;
                  fCH_QValue <= rec_w[15:0];
                end
                if (last_rec) begin
                  state <= rx_eop ? S_IDLE : S_DROP;
                end else if (rx_eop) begin
                  pkt_err <= 1'b1;
                  state   <= S_IDLE;
                end
              end else begin
                byte_idx <= byte_idx + 3'd1;
                if (rx_eop) begin
                  pkt_err <= 1'b1;
                  state   <= S_IDLE;
                end
              end
            end
            S_DROP: begin
              if (rx_eop)
                state <= S_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hb_chinfo_parser.sv
// Scoreboard bench for hb_chinfo_parser: default instance plus
// a MAX_REC=2 instance fed the same stream.
module tb_hb_chinfo_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_sop = 1'b0;
  logic        rx_eop = 1'b0;

  logic        hb0, en0, er0, hb1, en1, er1;
  logic [15:0] lim0, id0, hp0, qv0;
  logic [15:0] lim1, id1, hp1, qv1;

  always #5 clk = ~clk;

  hb_chinfo_parser u0 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .HB_reset(hb0), .HB_CHlimit(lim0), .en_KCH(en0),
    .fCH_ID(id0), .fCH_Hops(hp0), .fCH_QValue(qv0),
    .pkt_err(er0)
  );

  hb_chinfo_parser #(.MAX_REC(2)) u1 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .HB_reset(hb1), .HB_CHlimit(lim1), .en_KCH(en1),
    .fCH_ID(id1), .fCH_Hops(hp1), .fCH_QValue(qv1),
    .pkt_err(er1)
  );

  typedef struct packed {
    logic [1:0]  k;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } ev_t;

  localparam logic [1:0] K_HB  = 2'd0;
  localparam logic [1:0] K_REC = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  ev_t        q0[$];
  ev_t        q1[$];
  logic [7:0] pk[$];
  int         cmp_cnt = 0;
  int         fail_cnt = 0;

  function automatic ev_t mk(input logic [1:0] k,
                             input logic [15:0] a,
                             input logic [15:0] b,
                             input logic [15:0] c);
    ev_t e;
    e.k = k; e.a = a; e.b = b; e.c = c;
    return e;
  endfunction

  task automatic exp_hb(input logic [15:0] l);
    q0.push_back(mk(K_HB, l, 16'd0, 16'd0));
    q1.push_back(mk(K_HB, l, 16'd0, 16'd0));
  endtask

  task automatic exp_rec(input int idx, input logic [15:0] id,
                         input logic [15:0] hp,
                         input logic [15:0] qv);
    q0.push_back(mk(K_REC, id, hp, qv));
    if (idx < 2) q1.push_back(mk(K_REC, id, hp, qv));
  endtask

  task automatic exp_err();
    q0.push_back(mk(K_ERR, 16'd0, 16'd0, 16'd0));
    q1.push_back(mk(K_ERR, 16'd0, 16'd0, 16'd0));
  endtask

  task automatic check_ev(input int d, input ev_t got,
                          input string nm);
    ev_t e;
    cmp_cnt++;
    if ((d == 0 && q0.size() == 0) ||
        (d == 1 && q1.size() == 0)) begin
      fail_cnt++;
      $display("FAIL %s dut%0d: got %h, required no event",
               nm, d, got);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    if (got !== e) begin
      fail_cnt++;
      $display("FAIL %s dut%0d: got %h, required %h",
               nm, d, got, e);
    end
  endtask

  task automatic mon(input int d, input logic hb,
                     input logic [15:0] lim, input logic en,
                     input logic [15:0] id, input logic [15:0] hp,
                     input logic [15:0] qv, input logic er);
    if (hb) check_ev(d, mk(K_HB, lim, 16'd0, 16'd0), "hb_reset");
    if (en) check_ev(d, mk(K_REC, id, hp, qv), "en_kch");
    if (er) check_ev(d, mk(K_ERR, 16'd0, 16'd0, 16'd0), "pkt_err");
  endtask

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] req);
    cmp_cnt++;
    if (got !== req) begin
      fail_cnt++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  task automatic chk_reset(input string nm);
    check({nm, "_u0"},
          {13'd0, hb0, en0, er0, lim0, id0, hp0, qv0},
          {16'd0, 16'd0, 16'd0, 16'hFFFF, 16'd0});
    check({nm, "_u1"},
          {13'd0, hb1, en1, er1, lim1, id1, hp1, qv1},
          {16'd0, 16'd0, 16'd0, 16'hFFFF, 16'd0});
  endtask

  task automatic drive(input logic v, input logic [7:0] b,
                       input logic s, input logic e);
    @(posedge clk);
    #1;
    rx_valid = v; rx_byte = b; rx_sop = s; rx_eop = e;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic hdr(input logic [7:0] t, input logic [15:0] l,
                     input logic [7:0] n);
    pk.push_back(t);
    pk.push_back(l[15:8]);
    pk.push_back(l[7:0]);
    pk.push_back(n);
  endtask

  task automatic rec(input logic [15:0] id, input logic [15:0] hp,
                     input logic [15:0] qv);
    pk.push_back(id[15:8]); pk.push_back(id[7:0]);
    pk.push_back(hp[15:8]); pk.push_back(hp[7:0]);
    pk.push_back(qv[15:8]); pk.push_back(qv[7:0]);
  endtask

  // Sends pk with sop on the first byte, then deasserts rx_valid.
  task automatic send(input int stall_at, input int stall_n,
                      input logic with_eop);
    int n;
    n = pk.size();
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) idle(stall_n);
      drive(1'b1, pk[i], i == 0, with_eop && i == n - 1);
    end
    pk.delete();
    idle(1);
  endtask

  task automatic run_tests();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("reset_state");

    // Single record, plus exact latency and pulse width.
    exp_hb(16'd3);
    exp_rec(0, 16'd23, 16'd3, 16'h3000);
    hdr(8'h01, 16'd3, 8'd1);
    rec(16'h0017, 16'h0002, 16'h3000);
    send(-1, 0, 1'b1);
    @(negedge clk);
    check("latency_en", {63'd0, en0}, 64'd1);
    @(negedge clk);
    check("pulse_width", {63'd0, en0}, 64'd0);
    check("chlimit_held", {48'd0, lim0}, 64'd3);
    idle(2);

    // Three records with a stall mid-record; saturating hops.
    exp_hb(16'h0102);
    exp_rec(0, 16'd5, 16'd2, 16'h2000);
    exp_rec(1, 16'd9, 16'd1, 16'h3800);
    exp_rec(2, 16'd12, 16'hFFFF, 16'h1000);
    hdr(8'h01, 16'h0102, 8'd3);
    rec(16'd5, 16'd1, 16'h2000);
    rec(16'd9, 16'd0, 16'h3800);
    rec(16'd12, 16'hFFFF, 16'h1000);
    send(12, 2, 1'b1);
    idle(2);

    // Non-heartbeat packet, then a good heartbeat.
    hdr(8'h02, 16'h0101, 8'd1);
    for (int i = 0; i < 6; i++) pk.push_back(8'(i + 1));
    send(-1, 0, 1'b1);
    exp_hb(16'd9);
    exp_rec(0, 16'd42, 16'd1, 16'd1);
    hdr(8'h01, 16'd9, 8'd1);
    rec(16'd42, 16'd0, 16'd1);
    send(-1, 0, 1'b1);
    idle(2);

    // Truncated second record.
    exp_hb(16'd4);
    exp_rec(0, 16'd7, 16'd5, 16'h0100);
    exp_err();
    hdr(8'h01, 16'd4, 8'd2);
    rec(16'd7, 16'd4, 16'h0100);
    pk.push_back(8'h00); pk.push_back(8'h08);
    pk.push_back(8'h00);
    send(-1, 0, 1'b1);
    idle(2);

    // Four records: the MAX_REC=2 instance forwards two.
    exp_hb(16'h0020);
    for (int i = 0; i < 4; i++)
      exp_rec(i, 16'(i + 1), 16'(i + 1), 16'(i + 1));
    hdr(8'h01, 16'h0020, 8'd4);
    for (int i = 0; i < 4; i++)
      rec(16'(i + 1), 16'(i), 16'(i + 1));
    send(-1, 0, 1'b1);
    idle(2);

    // Truncated header, 1-byte packet, trailing bytes.
    exp_err();
    pk.push_back(8'h01); pk.push_back(8'h00);
    send(-1, 0, 1'b1);
    pk.push_back(8'h01);
    send(-1, 0, 1'b1);
    exp_hb(16'h0010);
    exp_rec(0, 16'h0100, 16'h0011, 16'h0020);
    hdr(8'h01, 16'h0010, 8'd1);
    rec(16'h0100, 16'h0010, 16'h0020);
    pk.push_back(8'hAA); pk.push_back(8'hBB);
    send(-1, 0, 1'b1);
    idle(2);

    // Header aborted by a new sop.
    hdr(8'h01, 16'h0055, 8'd1);
    void'(pk.pop_back());
    send(-1, 0, 1'b0);
    exp_hb(16'h0066);
    exp_rec(0, 16'd3, 16'd8, 16'd9);
    hdr(8'h01, 16'h0066, 8'd1);
    rec(16'd3, 16'd7, 16'd9);
    send(-1, 0, 1'b1);
    idle(2);

    // Reset on byte 4 of a record, then N=0 heartbeat.
    exp_hb(16'd5);
    hdr(8'h01, 16'd5, 8'd2);
    rec(16'h0033, 16'h0004, 16'h0055);
    for (int i = 0; i < 3; i++) void'(pk.pop_back());
    send(-1, 0, 1'b0);
    drive(1'b1, 8'h04, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("mid_rst");
    exp_hb(16'd7);
    hdr(8'h01, 16'd7, 8'd0);
    send(-1, 0, 1'b1);
    idle(3);
    @(negedge clk);
    check("n0_limit", {48'd0, lim0}, 64'd7);
    check("n0_hops", {48'd0, hp0}, 64'hFFFF);

    idle(4);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          mon(0, hb0, lim0, en0, id0, hp0, qv0, er0);
          mon(1, hb1, lim1, en1, id1, hp1, qv1, er1);
        end
      end
      run_tests();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures",
             cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
